rr_arb_mux: RTL

Registered N-input selector for the multicycle datapath; parametrised successor to the combinational 2:1 mux.
- Each input channel presents data with a valid/ready handshake.
- One channel is selected per cycle, either by round-robin arbitration or by a fixed select (classic mux mode).
- The winner is captured into a single output register, which also has a valid/ready handshake.
- Typical use: sharing one memory or ALU operand path among several requesters.

---
 rtl/rr_arb_mux.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/rr_arb_mux.sv
// Registered N-input selector with round-robin or fixed-select arbitration and valid/ready on both sides.
// Optional stall counter output is enabled by defining RR_ARB_MUX_STALL_CNT_EN.
module rr_arb_mux #(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel,
  output logic               out_valid,
  input  logic               out_ready
`ifdef RR_ARB_MUX_STALL_CNT_EN
  ,
  output logic [15:0]        stall_cnt
`endif
);

  logic [WIDTH-1:0] r_data;
  logic [SELW-1:0]  r_sel;
  logic             r_valid;
  logic [SELW-1:0]  r_ptr;

  logic             w_load;
  logic             w_found;
  logic [SELW-1:0]  w_grant;
  logic             w_xfer;
  logic [N-1:0]     w_ready;
  logic [WIDTH-1:0] w_win;

  // (base + off) mod N, with off < N so a single subtraction suffices
  function automatic logic [SELW-1:0] wrap_add(input logic [SELW-1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= 32'(N)) begin
      s = s - 32'(N);
    end else begin
      s = s;
    end
    return s[SELW-1:0];
  endfunction

  assign w_load = ~r_valid | out_ready;

  // Grant selection; the reverse scan lets the channel closest to the pointer win
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    if (mode == 1'b0) begin
      for (int k = N - 1; k >= 0; k--) begin
        if (in_valid[wrap_add(r_ptr, k)]) begin
          w_found = 1'b1;
          w_grant = wrap_add(r_ptr, k);
        end else begin
          w_found = w_found;
        end
      end
    end else begin
      if (32'(sel) < 32'(N)) begin
        if (in_valid[sel]) begin
          w_found = 1'b1;
          w_grant = sel;
        end else begin
          w_found = 1'b0;
        end
      end else begin
        w_found = 1'b0;
      end
    end
  end

  assign w_xfer = w_load & w_found & ~reset;

  // One-hot accept and data mux for the granted channel
  always_comb begin
    w_ready = '0;
    w_win   = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant == SELW'(i)) begin
        w_win      = in_data[i*WIDTH +: WIDTH];
        w_ready[i] = w_xfer;
      end else begin
        w_ready[i] = 1'b0;
      end
    end
  end

  assign in_ready = w_ready;

  // Output register and round-robin pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data  <= '0;
      r_sel   <= '0;
      r_valid <= 1'b0;
      r_ptr   <= '0;
    end else if (w_xfer) begin
      r_data  <= w_win;
      r_sel   <= w_grant;
      r_valid <= 1'b1;
      if (mode == 1'b0) begin
        r_ptr <= wrap_add(w_grant, 32'd1);
      end else begin
        r_ptr <= r_ptr;
      end
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign out_data  = r_data;
  assign out_sel   = r_sel;
  assign out_valid = r_valid;

`ifdef RR_ARB_MUX_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // Saturating count of cycles the held word is blocked downstream
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= 16'h0000;
    end else if (r_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'h0001;
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule
